// File: rtl/zap_wb_walk_arb.sv
// -----------------------------------------------------------------------------
// zap_wb_walk_arb
//
// Shares one Wishbone master port between the instruction-side (index 0) and
// data-side (index 1) page-table walkers. Each walker presents next-cycle
// ("_nxt") bus signals. The winner's signals are registered onto the shared
// bus. The grant is held for the whole cyc tenure. Round-robin between the two
// walkers breaks ties.
//
// Ports:
//   i_clk, i_reset_n          clock, asynchronous active-low reset
//   i_cyc_nxt/i_stb_nxt[1:0]  per-walker cycle request / strobe
//   i_adr_nxt0/1, i_wen_nxt,  per-walker address, write enable,
//   i_sel_nxt0/1, i_dat_nxt0/1  byte selects, write data
//   o_gnt[1:0]                one-hot current owner (0 when idle)
//   o_ack/o_err[1:0]          bus response steered to the owner only
//   o_dat                     read data, passed straight through
//   o_wb_*                    registered shared bus outputs
//   i_wb_dat/ack/err          bus slave response
//   o_timeout                 one-cycle pulse when a hung transfer is aborted
//
// A strobed transfer that sees no ack/err for TIMEOUT cycles is aborted. The
// arbiter returns a synthetic error to the owner, drops cyc/stb, and parks in
// ABORT until the owner releases its request. TIMEOUT = 0 disables the timeout.
// -----------------------------------------------------------------------------
module zap_wb_walk_arb #(
    parameter int TIMEOUT = 1024
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [1:0]  i_cyc_nxt,
    input  logic [1:0]  i_stb_nxt,
    input  logic [31:0] i_adr_nxt0,
    input  logic [31:0] i_adr_nxt1,
    input  logic [1:0]  i_wen_nxt,
    input  logic [3:0]  i_sel_nxt0,
    input  logic [3:0]  i_sel_nxt1,
    input  logic [31:0] i_dat_nxt0,
    input  logic [31:0] i_dat_nxt1,
    output logic [1:0]  o_gnt,
    output logic [1:0]  o_ack,
    output logic [1:0]  o_err,
    output logic [31:0] o_dat,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_wen,
    output logic [31:0] o_wb_adr,
    output logic [3:0]  o_wb_sel,
    output logic [31:0] o_wb_dat,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_ack,
    input  logic        i_wb_err,
    output logic        o_timeout
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic TO_EN = (TIMEOUT > 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN0  = 2'd1,
        OWN1  = 2'd2,
        ABORT = 2'd3
    } state_t;

    // One-hot grant vector for a requester index.
    function automatic logic [1:0] onehot2(input logic idx);
        onehot2 = idx ? 2'b10 : 2'b01;
    endfunction

    state_t           state_r, state_nxt_s;
    logic [1:0]       gnt_r, gnt_nxt_s;
    logic             last_r, last_nxt_s;
    logic [CNT_W-1:0] cnt_r;

    logic             cyc_r, stb_r, wen_r;
    logic [31:0]      adr_r, dat_r;
    logic [3:0]       sel_r;
    logic             cyc_nxt_s, stb_nxt_s, wen_nxt_s;
    logic [31:0]      adr_nxt_s, dat_nxt_s;
    logic [3:0]       sel_nxt_s;

    logic             own_idx_s;
    logic             owning_s;
    logic             win_idle_s;
    logic             fire_s;
    logic             load_s;
    logic             load_idx_s;

    // Owner index, ownership flag, idle tie-break and timeout-fire condition.
    always_comb begin
        own_idx_s  = gnt_r[1];
        owning_s   = (state_r == OWN0) || (state_r == OWN1);
        // On a tie, grant the walker that did not own the bus last time.
        win_idle_s = (&i_cyc_nxt) ? ~last_r : i_cyc_nxt[1];
        // A real ack/err arriving in the last cycle wins over the abort.
        fire_s     = TO_EN && owning_s && stb_r && !i_wb_ack && !i_wb_err
                     && (cnt_r == CNT_LAST);
    end

    // Next-state, grant, pointer and next bus values.
    always_comb begin
        state_nxt_s = state_r;
        gnt_nxt_s   = gnt_r;
        last_nxt_s  = last_r;
        load_s      = 1'b0;
        load_idx_s  = 1'b0;
        // The bus is idle unless a requester is loaded below. Payload fields
        // hold their value so they do not toggle while the bus is idle.
        cyc_nxt_s   = 1'b0;
        stb_nxt_s   = 1'b0;
        wen_nxt_s   = wen_r;
        adr_nxt_s   = adr_r;
        sel_nxt_s   = sel_r;
        dat_nxt_s   = dat_r;

        case (state_r)
            IDLE: begin
                if (|i_cyc_nxt) begin
                    load_s     = 1'b1;
                    load_idx_s = win_idle_s;
                end else begin
                    gnt_nxt_s = 2'b00;
                end
            end
            OWN0, OWN1: begin
                if (fire_s) begin
                    state_nxt_s = ABORT;
                end else if (i_cyc_nxt[own_idx_s]) begin
                    load_s     = 1'b1;
                    load_idx_s = own_idx_s;
                end else begin
                    last_nxt_s = own_idx_s;
                    if (i_cyc_nxt[~own_idx_s]) begin
                        // Back-to-back handoff with no idle bus cycle.
                        load_s     = 1'b1;
                        load_idx_s = ~own_idx_s;
                    end else begin
                        state_nxt_s = IDLE;
                        gnt_nxt_s   = 2'b00;
                    end
                end
            end
            ABORT: begin
                if (i_cyc_nxt[own_idx_s]) begin
                    state_nxt_s = ABORT;
                end else begin
                    last_nxt_s = own_idx_s;
                    if (i_cyc_nxt[~own_idx_s]) begin
                        load_s     = 1'b1;
                        load_idx_s = ~own_idx_s;
                    end else begin
                        state_nxt_s = IDLE;
                        gnt_nxt_s   = 2'b00;
                    end
                end
            end
            default: begin
                state_nxt_s = IDLE;
                gnt_nxt_s   = 2'b00;
            end
        endcase

        if (load_s) begin
            state_nxt_s = load_idx_s ? OWN1 : OWN0;
            gnt_nxt_s   = onehot2(load_idx_s);
            cyc_nxt_s   = i_cyc_nxt[load_idx_s];
            stb_nxt_s   = i_stb_nxt[load_idx_s];
            wen_nxt_s   = i_wen_nxt[load_idx_s];
            adr_nxt_s   = load_idx_s ? i_adr_nxt1 : i_adr_nxt0;
            sel_nxt_s   = load_idx_s ? i_sel_nxt1 : i_sel_nxt0;
            dat_nxt_s   = load_idx_s ? i_dat_nxt1 : i_dat_nxt0;
        end else begin
            // Keep the values chosen in the state decode above.
            state_nxt_s = state_nxt_s;
        end
    end

    // State, grant and last-owner pointer registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r <= IDLE;
            gnt_r   <= 2'b00;
            last_r  <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            gnt_r   <= gnt_nxt_s;
            last_r  <= last_nxt_s;
        end
    end

    // Shared bus output registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cyc_r <= 1'b0;
            stb_r <= 1'b0;
            wen_r <= 1'b0;
            adr_r <= 32'h0000_0000;
            sel_r <= 4'h0;
            dat_r <= 32'h0000_0000;
        end else begin
            cyc_r <= cyc_nxt_s;
            stb_r <= stb_nxt_s;
            wen_r <= wen_nxt_s;
            adr_r <= adr_nxt_s;
            sel_r <= sel_nxt_s;
            dat_r <= dat_nxt_s;
        end
    end

    // Timeout counter: counts strobed cycles without a response and
    // restarts on any response or change of state.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_r <= '0;
        end else if ((state_nxt_s != state_r) || i_wb_ack || i_wb_err) begin
            cnt_r <= '0;
        end else if (TO_EN && owning_s && stb_r) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // The response return path is combinational and steered to the owner only.
    always_comb begin
        o_gnt     = gnt_r;
        o_ack     = {2{i_wb_ack}} & gnt_r;
        o_err     = {2{i_wb_err | fire_s}} & gnt_r;
        o_timeout = fire_s;
        o_dat     = i_wb_dat;
        o_wb_cyc  = cyc_r;
        o_wb_stb  = stb_r;
        o_wb_wen  = wen_r;
        o_wb_adr  = adr_r;
        o_wb_sel  = sel_r;
        o_wb_dat  = dat_r;
    end

endmodule

// File: tb/tb_zap_wb_walk_arb.sv
module tb_zap_wb_walk_arb;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic [1:0]  i_cyc_nxt, i_stb_nxt, i_wen_nxt;
    logic [31:0] i_adr_nxt0, i_adr_nxt1, i_dat_nxt0, i_dat_nxt1;
    logic [3:0]  i_sel_nxt0, i_sel_nxt1;
    logic [1:0]  o_gnt, o_ack, o_err;
    logic [31:0] o_dat, o_wb_adr, o_wb_dat, i_wb_dat;
    logic        o_wb_cyc, o_wb_stb, o_wb_wen;
    logic [3:0]  o_wb_sel;
    logic        i_wb_ack, i_wb_err, o_timeout;

    int tests = 0;
    int failed = 0;

    zap_wb_walk_arb #(.TIMEOUT(8)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_cyc_nxt(i_cyc_nxt), .i_stb_nxt(i_stb_nxt),
        .i_adr_nxt0(i_adr_nxt0), .i_adr_nxt1(i_adr_nxt1),
        .i_wen_nxt(i_wen_nxt),
        .i_sel_nxt0(i_sel_nxt0), .i_sel_nxt1(i_sel_nxt1),
        .i_dat_nxt0(i_dat_nxt0), .i_dat_nxt1(i_dat_nxt1),
        .o_gnt(o_gnt), .o_ack(o_ack), .o_err(o_err), .o_dat(o_dat),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_wen(o_wb_wen),
        .o_wb_adr(o_wb_adr), .o_wb_sel(o_wb_sel), .o_wb_dat(o_wb_dat),
        .i_wb_dat(i_wb_dat), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
        .o_timeout(o_timeout)
    );

    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        i_reset_n = 1'b0;
        step();
        step();
        i_reset_n = 1'b1;
    endtask

    initial begin
        i_reset_n  = 1'b0;
        i_cyc_nxt  = 2'b00;  i_stb_nxt  = 2'b00;  i_wen_nxt  = 2'b00;
        i_adr_nxt0 = 32'h0;  i_adr_nxt1 = 32'h0;
        i_dat_nxt0 = 32'h0;  i_dat_nxt1 = 32'h0;
        i_sel_nxt0 = 4'hF;   i_sel_nxt1 = 4'hF;
        i_wb_dat   = 32'h0;  i_wb_ack   = 1'b0;   i_wb_err  = 1'b0;

        // Reset state
        do_reset();
        chk("rst_gnt", 32'(o_gnt), 32'h0);
        chk("rst_cyc", 32'(o_wb_cyc), 32'h0);
        chk("rst_stb", 32'(o_wb_stb), 32'h0);
        chk("rst_adr", o_wb_adr, 32'h0);
        chk("rst_timeout", 32'(o_timeout), 32'h0);

        // 1. Single requester read
        i_cyc_nxt = 2'b01; i_stb_nxt = 2'b01; i_adr_nxt0 = 32'h0000_4000;
        step();
        chk("t1_cyc", 32'(o_wb_cyc), 32'h1);
        chk("t1_stb", 32'(o_wb_stb), 32'h1);
        chk("t1_adr", o_wb_adr, 32'h0000_4000);
        chk("t1_gnt", 32'(o_gnt), 32'h1);
        i_wb_ack = 1'b1; i_wb_dat = 32'hDEAD_BEEF;
        i_cyc_nxt = 2'b00; i_stb_nxt = 2'b00;
        #1;
        chk("t1_ack", 32'(o_ack), 32'h1);
        chk("t1_dat", o_dat, 32'hDEAD_BEEF);
        step();
        i_wb_ack = 1'b0;
        chk("t1_rel_cyc", 32'(o_wb_cyc), 32'h0);
        chk("t1_rel_gnt", 32'(o_gnt), 32'h0);

        // 2. Tie after reset, back-to-back handoff, round-robin
        do_reset();
        i_cyc_nxt = 2'b11; i_stb_nxt = 2'b11;
        i_adr_nxt0 = 32'h0000_00A0; i_adr_nxt1 = 32'h0000_00B0;
        step();
        chk("t2_gnt0", 32'(o_gnt), 32'h1);
        chk("t2_adr0", o_wb_adr, 32'h0000_00A0);
        i_cyc_nxt = 2'b10; i_stb_nxt = 2'b10;
        step();
        chk("t2_gnt1", 32'(o_gnt), 32'h2);
        chk("t2_cyc_b2b", 32'(o_wb_cyc), 32'h1);
        chk("t2_adr1", o_wb_adr, 32'h0000_00B0);
        i_cyc_nxt = 2'b00; i_stb_nxt = 2'b00;
        step();
        chk("t2_idle_gnt", 32'(o_gnt), 32'h0);
        i_cyc_nxt = 2'b11; i_stb_nxt = 2'b11;
        step();
        chk("t2_rr_gnt", 32'(o_gnt), 32'h1);
        i_cyc_nxt = 2'b00; i_stb_nxt = 2'b00;
        step();
        chk("t2_rr_idle", 32'(o_wb_cyc), 32'h0);

        // 3. Lock: requester 1 owns a 3-beat transfer while requester 0 waits
        i_cyc_nxt = 2'b10; i_stb_nxt = 2'b10; i_adr_nxt1 = 32'h0000_1000;
        step();
        chk("t3_gnt", 32'(o_gnt), 32'h2);
        i_cyc_nxt = 2'b11; i_stb_nxt = 2'b11; i_adr_nxt0 = 32'h0000_2000;
        for (int b = 0; b < 3; b++) begin
            i_adr_nxt1 = 32'h0000_1004 + 32'(b * 4);
            i_stb_nxt  = 2'b11;
            step();
            i_wb_ack = 1'b1;
            #1;
            chk("t3_beat_gnt", 32'(o_gnt), 32'h2);
            chk("t3_beat_adr", o_wb_adr, 32'h0000_1004 + 32'(b * 4));
            chk("t3_beat_ack", 32'(o_ack), 32'h2);
            i_stb_nxt = 2'b01;
            step();
            i_wb_ack = 1'b0;
            chk("t3_gap_stb", 32'(o_wb_stb), 32'h0);
            chk("t3_gap_gnt", 32'(o_gnt), 32'h2);
        end
        i_cyc_nxt = 2'b01; i_stb_nxt = 2'b01;
        step();
        chk("t3_hand_gnt", 32'(o_gnt), 32'h1);
        chk("t3_hand_adr", o_wb_adr, 32'h0000_2000);
        i_cyc_nxt = 2'b00; i_stb_nxt = 2'b00;
        step();

        // 4. Timeout on requester 1
        i_cyc_nxt = 2'b10; i_stb_nxt = 2'b10; i_adr_nxt1 = 32'h0000_3000;
        step();
        for (int c = 1; c < 8; c++) begin
            chk("t4_no_to", 32'(o_timeout), 32'h0);
            chk("t4_no_err", 32'(o_err), 32'h0);
            step();
        end
        chk("t4_err", 32'(o_err), 32'h2);
        chk("t4_timeout", 32'(o_timeout), 32'h1);
        step();
        chk("t4_abort_cyc", 32'(o_wb_cyc), 32'h0);
        chk("t4_abort_gnt", 32'(o_gnt), 32'h2);
        chk("t4_abort_to", 32'(o_timeout), 32'h0);
        step();
        chk("t4_abort_hold", 32'({o_wb_cyc, o_gnt}), 32'h2);
        i_cyc_nxt = 2'b00; i_stb_nxt = 2'b00;
        step();
        chk("t4_exit_gnt", 32'(o_gnt), 32'h0);

        // 5. Ack in the last cycle before the timeout
        i_cyc_nxt = 2'b01; i_stb_nxt = 2'b01;
        step();
        for (int c = 1; c < 8; c++) step();
        i_wb_ack = 1'b1;
        #1;
        chk("t5_ack", 32'(o_ack), 32'h1);
        chk("t5_err", 32'(o_err), 32'h0);
        chk("t5_timeout", 32'(o_timeout), 32'h0);
        step();
        i_wb_ack = 1'b0;
        chk("t5_still_cyc", 32'(o_wb_cyc), 32'h1);
        chk("t5_still_gnt", 32'(o_gnt), 32'h1);
        i_cyc_nxt = 2'b00; i_stb_nxt = 2'b00;
        step();

        // 6. Reset mid-transfer
        i_cyc_nxt = 2'b10; i_stb_nxt = 2'b10;
        step();
        chk("t6_own1", 32'(o_gnt), 32'h2);
        i_reset_n = 1'b0;
        i_cyc_nxt = 2'b11; i_stb_nxt = 2'b11;
        #1;
        chk("t6_async_cyc", 32'(o_wb_cyc), 32'h0);
        chk("t6_async_gnt", 32'(o_gnt), 32'h0);
        step();
        i_reset_n = 1'b1;
        step();
        chk("t6_tie_gnt", 32'(o_gnt), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
